// File: rtl/demux8_deser_pkg.sv
// -----------------------------------------------------------------------------
// demux8_pkg
// Shared constants and types for the 1:8 serial-to-parallel demultiplexer.
//   SLOTS          : channels per frame (fixed at 8)
//   SLOT_W         : width of the slot index
//   demux8_state_t : receive FSM states (IDLE = unsynchronised, COLLECT = in frame)
// -----------------------------------------------------------------------------
package demux8_pkg;

  localparam int SLOTS  = 8;
  localparam int SLOT_W = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } demux8_state_t;

endpackage

// File: rtl/demux8_deser_if.sv
// -----------------------------------------------------------------------------
// demux8_deser_if
// Serial input beat and parallel frame output of demux8_deser, bundled.
//   in, in_valid, frame_start : serial beat from the producer
//   out, out_valid, out_ready : completed frame, valid/ready handshake
//   slot                      : index the next accepted bit will occupy
//   frame_err                 : one-cycle pulse, frame_start arrived mid-frame
//   overrun                   : sticky, an unaccepted frame was replaced
// master = producer/consumer side, slave = demultiplexer side.
// -----------------------------------------------------------------------------
interface demux8_deser_if;
  import demux8_pkg::*;

  logic              in;
  logic              in_valid;
  logic              frame_start;
  logic [SLOTS-1:0]  out;
  logic              out_valid;
  logic              out_ready;
  logic [SLOT_W-1:0] slot;
  logic              frame_err;
  logic              overrun;

  modport master (
    output in, in_valid, frame_start, out_ready,
    input  out, out_valid, slot, frame_err, overrun
  );

  modport slave (
    input  in, in_valid, frame_start, out_ready,
    output out, out_valid, slot, frame_err, overrun
  );

endinterface

// File: rtl/demux8_deser_slot_counter.sv
// -----------------------------------------------------------------------------
// slot_counter
// Slot index counter for the demultiplexer.
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance the count by one (wraps 7 -> 0)
//   load1    : synchronous load to 1 (beat at slot 0 on frame_start); wins over en
//   count_r  : current slot index
//   wrap_s   : count_r is on the last slot of the frame
// -----------------------------------------------------------------------------
module slot_counter
  import demux8_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load1,
  output logic [SLOT_W-1:0] count_r,
  output logic              wrap_s
);

  // Slot index register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {SLOT_W{1'b0}};
    end else if (load1) begin
      count_r <= SLOT_W'(1);
    end else if (en) begin
      count_r <= count_r + SLOT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign wrap_s = (count_r == SLOT_W'(SLOTS - 1));

endmodule

// File: rtl/demux8_deser.sv
// -----------------------------------------------------------------------------
// demux8_deser
// Serial-to-parallel 1:8 demultiplexer. Slot k of a framed bit stream lands in
// out[k]. Completed frames are held in a single output register with a
// valid/ready handshake; overrun and mid-frame resync are reported.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : demux8_deser_if.slave (serial input, frame output, status)
// -----------------------------------------------------------------------------
module demux8_deser
  import demux8_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  demux8_deser_if.slave  bus
);

  demux8_state_t     state_r;
  demux8_state_t     state_nxt_s;
  logic [SLOT_W-1:0] slot_s;
  logic              wrap_s;
  logic              start_s;
  logic              cnt_en_s;
  logic              cnt_load_s;
  logic              stage_wr_s;
  logic              complete_s;
  logic              err_s;
  logic [SLOT_W-1:0] wr_idx_s;
  logic [SLOTS-1:0]  staging_r;
  logic [SLOTS-1:0]  out_r;
  logic              out_valid_r;
  logic              frame_err_r;
  logic              overrun_r;

  assign start_s  = bus.in_valid & bus.frame_start;
  // A frame_start beat always goes to slot 0, whatever the counter says.
  assign wr_idx_s = cnt_load_s ? {SLOT_W{1'b0}} : slot_s;

  slot_counter u_slot_counter (
    .clk     (clk),
    .rst     (rst),
    .en      (cnt_en_s),
    .load1   (cnt_load_s),
    .count_r (slot_s),
    .wrap_s  (wrap_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic: once synchronised, only reset leaves COLLECT.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nxt_s = COLLECT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COLLECT: state_nxt_s = COLLECT;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output decode: counter control, staging write, completion, error.
  always_comb begin
    cnt_en_s   = 1'b0;
    cnt_load_s = 1'b0;
    stage_wr_s = 1'b0;
    complete_s = 1'b0;
    err_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          cnt_load_s = 1'b1;
          stage_wr_s = 1'b1;
        end else begin
          cnt_load_s = 1'b0;
        end
      end
      COLLECT: begin
        if (start_s) begin
          // Resync: partial frame is abandoned; only an error if mid-frame.
          cnt_load_s = 1'b1;
          stage_wr_s = 1'b1;
          err_s      = (slot_s != {SLOT_W{1'b0}});
        end else if (bus.in_valid) begin
          cnt_en_s   = 1'b1;
          stage_wr_s = 1'b1;
          complete_s = wrap_s;
        end else begin
          cnt_en_s   = 1'b0;
        end
      end
      default: begin
        cnt_en_s = 1'b0;
      end
    endcase
  end

  // Staging register: one bit per slot, written as beats arrive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staging_r <= {SLOTS{1'b0}};
    end else if (stage_wr_s) begin
      staging_r[wr_idx_s] <= bus.in;
    end else begin
      staging_r <= staging_r;
    end
  end

  // Output frame register and handshake; completion wins over acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r       <= {SLOTS{1'b0}};
      out_valid_r <= 1'b0;
    end else if (complete_s) begin
      out_r       <= {bus.in, staging_r[SLOTS-2:0]};
      out_valid_r <= 1'b1;
    end else if (out_valid_r && bus.out_ready) begin
      out_r       <= out_r;
      out_valid_r <= 1'b0;
    end else begin
      out_r       <= out_r;
      out_valid_r <= out_valid_r;
    end
  end

  // Error flags: frame_err is a one-cycle pulse, overrun is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= err_s;
      if (complete_s && out_valid_r && !bus.out_ready) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign bus.out       = out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.slot      = slot_s;
  assign bus.frame_err = frame_err_r;
  assign bus.overrun   = overrun_r;

endmodule
